// File: rtl/cnn_layer_accel_awe_stride_ctrl.sv
// 2-D stride scheduler for the AWE output path: walks the raster pixel stream
// with row/column phase counters and forwards only stride-grid pixels with output coordinates.
module cnn_layer_accel_awe_stride_ctrl #(
  parameter int C_DATA_WIDTH   = 16,
  parameter int C_MAX_STRIDE   = 8,
  parameter int C_DIM_WIDTH    = 10,
  parameter int C_STRIDE_WIDTH = $clog2(C_MAX_STRIDE + 1),
  localparam int C_PICK_WIDTH  = $clog2(C_MAX_STRIDE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [C_DIM_WIDTH-1:0]    cfg_num_rows,
  input  logic [C_DIM_WIDTH-1:0]    cfg_num_cols,
  input  logic [C_STRIDE_WIDTH-1:0] cfg_stride,
  output logic                      cfg_err,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      picker_config_valid,
  output logic [C_PICK_WIDTH-1:0]   picker_stride_size,
  input  logic [C_DATA_WIDTH-1:0]   s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [C_DATA_WIDTH-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [C_DIM_WIDTH-1:0]    m_row,
  output logic [C_DIM_WIDTH-1:0]    m_col,
  output logic                      m_last,
  output logic [2:0]                dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // valid never waits on ready; payload holds while valid && !ready.

  typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [C_DIM_WIDTH-1:0]    DIM_ONE = C_DIM_WIDTH'(1);
  localparam logic [C_STRIDE_WIDTH-1:0] STR_ONE = C_STRIDE_WIDTH'(1);
  localparam logic [C_STRIDE_WIDTH-1:0] MAX_S   = C_STRIDE_WIDTH'(C_MAX_STRIDE);

  state_t                    state;
  logic [C_DIM_WIDTH-1:0]    rows_r, cols_r;
  logic [C_STRIDE_WIDTH-1:0] stride_r, stride_in;
  logic                      cfg_err_r;
  logic [C_DIM_WIDTH-1:0]    row, col, out_row, out_col;
  logic [C_STRIDE_WIDTH-1:0] row_phase, col_phase;

  logic                      fire, keep, last_col, last_row, row_wrap, col_wrap;
  logic                      start_ok, is_last;
  logic [C_DIM_WIDTH:0]      stride_ext, row_sum, col_sum;

  assign cfg_ready           = (state == S_IDLE);
  assign busy                = (state == S_CONFIG) || (state == S_RUN) || (state == S_FLUSH);
  assign done                = (state == S_DONE);
  assign cfg_err             = cfg_err_r;
  assign picker_config_valid = (state == S_CONFIG);
  assign picker_stride_size  = (state == S_CONFIG) ? C_PICK_WIDTH'(stride_r - STR_ONE) : '0;
  assign dbg_state           = state;

  assign s_ready  = (state == S_RUN) && (!m_valid || m_ready);
  assign fire     = s_valid && s_ready;
  assign keep     = (row_phase == '0) && (col_phase == '0);
  assign last_col = (col == cols_r - DIM_ONE);
  assign last_row = (row == rows_r - DIM_ONE);
  assign row_wrap = (row_phase == stride_r - STR_ONE);
  assign col_wrap = (col_phase == stride_r - STR_ONE);

  // One extra bit so row+stride cannot wrap near the top of the index range.
  assign stride_ext = (C_DIM_WIDTH + 1)'(stride_r);
  assign row_sum    = {1'b0, row} + stride_ext;
  assign col_sum    = {1'b0, col} + stride_ext;
  assign is_last    = (row_sum >= {1'b0, rows_r}) && (col_sum >= {1'b0, cols_r});

  assign start_ok = start && !cfg_valid && !cfg_err_r && (rows_r != '0) && (cols_r != '0);

  always_comb begin
    stride_in = cfg_stride;
    if (cfg_stride == '0)
      stride_in = STR_ONE;
    else if (cfg_stride > MAX_S)
      stride_in = MAX_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rows_r    <= '0;
      cols_r    <= '0;
      stride_r  <= '0;
      cfg_err_r <= 1'b0;
      row       <= '0;
      col       <= '0;
      out_row   <= '0;
      out_col   <= '0;
      row_phase <= '0;
      col_phase <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_row     <= '0;
      m_col     <= '0;
      m_last    <= 1'b0;
    end else begin
      // A new kept beat can replace the one draining in the same cycle.
      if (fire && keep) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_row   <= out_row;
        m_col   <= out_col;
        m_last  <= is_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            rows_r    <= cfg_num_rows;
            cols_r    <= cfg_num_cols;
            stride_r  <= stride_in;
            cfg_err_r <= (cfg_num_rows == '0) || (cfg_num_cols == '0);
          end else if (start_ok) begin
            state <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          row       <= '0;
          col       <= '0;
          out_row   <= '0;
          out_col   <= '0;
          row_phase <= '0;
          col_phase <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (fire) begin
            if (last_col) begin
              col       <= '0;
              col_phase <= '0;
              out_col   <= '0;
              row       <= row + DIM_ONE;
              row_phase <= row_wrap ? '0 : row_phase + STR_ONE;
              if (row_wrap) out_row <= out_row + DIM_ONE;
              if (last_row) state <= S_FLUSH;
            end else begin
              col       <= col + DIM_ONE;
              col_phase <= col_wrap ? '0 : col_phase + STR_ONE;
              if (col_wrap) out_col <= out_col + DIM_ONE;
            end
          end
        end
        S_FLUSH: begin
          if (!m_valid || m_ready) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_ctrl.sv
// Bench for the stride scheduler: randomized frames checked against a
// raster-walk reference model (expected output queue built with plain arithmetic).
module tb_cnn_layer_accel_awe_stride_ctrl;

  localparam int DW   = 16;
  localparam int MS   = 8;
  localparam int DIMW = 10;
  localparam int SW   = 4;
  localparam int PW   = 3;
  localparam int EW   = DW + 2 * DIMW + 1;

  logic            clk, rst;
  logic            cfg_valid, cfg_ready, cfg_err, start, busy, done;
  logic [DIMW-1:0] cfg_num_rows, cfg_num_cols;
  logic [SW-1:0]   cfg_stride;
  logic            picker_config_valid;
  logic [PW-1:0]   picker_stride_size;
  logic [DW-1:0]   s_data, m_data;
  logic            s_valid, s_ready, m_valid, m_ready, m_last;
  logic [DIMW-1:0] m_row, m_col;
  logic [2:0]      dbg_state;

  cnn_layer_accel_awe_stride_ctrl #(
    .C_DATA_WIDTH(DW), .C_MAX_STRIDE(MS), .C_DIM_WIDTH(DIMW), .C_STRIDE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols), .cfg_stride(cfg_stride),
    .cfg_err(cfg_err), .start(start), .busy(busy), .done(done),
    .picker_config_valid(picker_config_valid), .picker_stride_size(picker_stride_size),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] pix[$];
  logic [PW-1:0] exp_pick;
  int done_cnt = 0;
  int pick_cnt = 0;
  int done_cyc = 0;
  int last_fire_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: raster walk, keep pixels whose row and column are multiples of the stride.
  task automatic build_model(input int rows, input int cols, input int stride, input bit raster);
    int s;
    logic [DW-1:0]   d;
    logic [DIMW-1:0] orow, ocol;
    logic            lst;
    s = (stride == 0) ? 1 : ((stride > MS) ? MS : stride);
    exp_pick = PW'(s - 1);
    pix.delete();
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        d = raster ? DW'(r * cols + c) : DW'($urandom);
        pix.push_back(d);
        if ((r % s == 0) && (c % s == 0)) begin
          orow = DIMW'(r / s);
          ocol = DIMW'(c / s);
          lst  = (r + s >= rows) && (c + s >= cols);
          exp_q.push_back({d, orow, ocol, lst});
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (m_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", m_valid, 1'b0);
        else begin
          chk("out_beat", {m_data, m_row, m_col, m_last}, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) last_fire_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (picker_config_valid) begin
        pick_cnt++;
        chk("picker_stride_size", picker_stride_size, exp_pick);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input int k);
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (k % 2 == 0);
      default: m_ready = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  task automatic do_cfg(input int rows, input int cols, input int stride);
    cfg_valid    = 1'b1;
    cfg_num_rows = DIMW'(rows);
    cfg_num_cols = DIMW'(cols);
    cfg_stride   = SW'(stride);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic stream(input int mode, input bit gap, input bit poke, input int abort_after);
    int idx = 0;
    int k = 0;
    int total;
    bit fire;
    total = pix.size();
    while (idx < total && k < 4000) begin
      s_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = pix[idx];
      set_ready(mode, k);
      if (poke && k == 5) begin
        cfg_valid    = 1'b1;
        cfg_num_rows = DIMW'(1);
        cfg_num_cols = DIMW'(1);
        cfg_stride   = SW'(3);
      end
      @(negedge clk);
      if (poke && k == 5) chk("cfg_ready_in_run", cfg_ready, 1'b0);
      fire = s_valid && s_ready;
      cycle();
      cfg_valid = 1'b0;
      if (fire) idx++;
      k++;
      if (abort_after > 0 && idx >= abort_after) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    if (idx < total) chk("stream_timeout", idx, total);
  endtask

  task automatic drain(input int mode, input int done0);
    int k = 0;
    while (done_cnt == done0 && k < 300) begin
      set_ready(mode, k);
      cycle();
      k++;
    end
    m_ready = 1'b1;
    if (done_cnt == done0) chk("done_timeout", done_cnt - done0, 1);
  endtask

  task automatic run_frame(input int rows, input int cols, input int stride, input bit raster,
                           input int mode, input bit gap, input bit poke);
    int done0, pick0;
    do_cfg(rows, cols, stride);
    chk("cfg_err_clear", cfg_err, 1'b0);
    build_model(rows, cols, stride, raster);
    done0 = done_cnt;
    pick0 = pick_cnt;
    do_start();
    stream(mode, gap, poke, 0);
    drain(mode, done0);
    chk("frame_drained", exp_q.size(), 0);
    chk("done_pulses", done_cnt - done0, 1);
    chk("picker_pulses", pick_cnt - pick0, 1);
    chk("busy_after_done", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rows, cols, strd;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_num_rows = '0; cfg_num_cols = '0; cfg_stride = '0;
    start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_outputs", {busy, done, cfg_err, picker_config_valid, picker_stride_size, s_ready,
                        m_valid, m_data, m_row, m_col, m_last}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // Model pins against hand-computed values.
    build_model(4, 4, 2, 1'b1);
    chk("pin_4x4_size", exp_q.size(), 4);
    chk("pin_4x4_first", exp_q[0], {16'd0, 10'd0, 10'd0, 1'b0});
    chk("pin_4x4_second", exp_q[1], {16'd2, 10'd0, 10'd1, 1'b0});
    chk("pin_4x4_last", exp_q[3], {16'd10, 10'd1, 10'd1, 1'b1});
    build_model(5, 5, 2, 1'b1);
    chk("pin_5x5_size", exp_q.size(), 9);
    chk("pin_5x5_last", exp_q[8], {16'd24, 10'd2, 10'd2, 1'b1});
    build_model(3, 3, 10, 1'b1);
    chk("pin_clamp_size", exp_q.size(), 1);
    chk("pin_clamp_pick", exp_pick, 3'd7);
    exp_q.delete();

    // 4x4 stride 2, free-flowing output; done two cycles after the final input beat.
    run_frame(4, 4, 2, 1'b1, 0, 1'b0, 1'b0);
    chk("done_latency", done_cyc - last_fire_cyc, 2);

    // 3x3 stride 1 pass-through.
    run_frame(3, 3, 1, 1'b1, 0, 1'b0, 1'b0);

    // 5x5 stride 2 with toggling m_ready and input gaps, plus a cfg attempt mid-run.
    run_frame(5, 5, 2, 1'b1, 1, 1'b1, 1'b1);

    // Zero rows: error flag, start ignored.
    do_cfg(0, 5, 2);
    chk("cfg_err_rows0", cfg_err, 1'b1);
    do_start();
    repeat (3) begin
      @(negedge clk);
      chk("busy_after_bad_start", busy, 1'b0);
    end
    cycle();
    // Stride 0 is treated as 1.
    run_frame(2, 2, 0, 1'b1, 0, 1'b0, 1'b0);

    // start together with cfg_valid is ignored.
    do_cfg(3, 3, 1);
    cfg_valid = 1'b1; start = 1'b1;
    cycle();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("busy_start_with_cfg", busy, 1'b0);
    end
    cycle();

    // Reset mid-frame after 6 beats: no done, everything cleared.
    begin
      int done0;
      do_cfg(6, 6, 2);
      build_model(6, 6, 2, 1'b0);
      done0 = done_cnt;
      do_start();
      stream(0, 1'b0, 1'b0, 6);
      rst = 1'b1;
      #1;
      chk("midrst_cfg_ready", cfg_ready, 1'b1);
      chk("midrst_outputs", {busy, done, cfg_err, picker_config_valid, picker_stride_size, s_ready,
                             m_valid, m_data, m_row, m_col, m_last}, '0);
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
      cycle();
      chk("midrst_no_done", done_cnt - done0, 0);
    end
    run_frame(6, 6, 2, 1'b0, 2, 1'b1, 1'b0);

    // 1x1 frame and randomized frames, including stride clamping.
    run_frame(1, 1, 3, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rows = $urandom_range(1, 12);
      cols = $urandom_range(1, 12);
      strd = $urandom_range(0, 10);
      run_frame(rows, cols, strd, 1'b0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_awe_stride_ctrl.md
Name: cnn_layer_accel_awe_stride_ctrl

Overview:
2-D stride scheduler for the AWE output path. It loads a layer configuration and, on start, pulses config into the per-lane stride pickers. It then walks the raster-ordered AWE output stream with row and column phase counters and forwards only pixels on the stride grid, tagged with output coordinates. It raises done once the frame has fully drained. Sits between the AWE array outputs and the output buffer.

Parameters:
C_DATA_WIDTH, 16, pixel width
C_MAX_STRIDE, 8, largest supported stride
C_DIM_WIDTH, 10, width of row/column counts and indices
C_STRIDE_WIDTH, clog2(C_MAX_STRIDE+1), width of cfg_stride

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cfg_valid  in  1  configuration present
cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid
cfg_num_rows  in  C_DIM_WIDTH  input frame rows
cfg_num_cols  in  C_DIM_WIDTH  input frame columns
cfg_stride  in  C_STRIDE_WIDTH  stride, 1..C_MAX_STRIDE
cfg_err  out  1  latched config invalid (sticky until next accepted cfg)
start  in  1  begin frame (pulse)
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame completion
picker_config_valid  out  1  config pulse to stride pickers
picker_stride_size  out  clog2(C_MAX_STRIDE)  stride-1 to pickers
s_data  in  C_DATA_WIDTH  input pixel
s_valid  in  1  input valid
s_ready  out  1  input ready
m_data  out  C_DATA_WIDTH  kept pixel
m_valid  out  1  output valid
m_ready  in  1  output ready
m_row  out  C_DIM_WIDTH  output row index (input row / stride)
m_col  out  C_DIM_WIDTH  output column index
m_last  out  1  final kept pixel of frame

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0 except cfg_ready=1; counters and config regs 0; output register emptied. Reset mid-frame aborts with no done.
- States: IDLE, CONFIG, RUN, FLUSH, DONE.
- IDLE: cfg_ready=1; cfg_valid latches rows, cols, stride. Stride 0 is latched as 1; stride >C_MAX_STRIDE is clamped to C_MAX_STRIDE. cfg_err=1 iff rows==0 or cols==0.
- IDLE start: accepted only when cfg_err=0 and cfg_valid is low the same cycle; otherwise ignored. On accept -> CONFIG.
- CONFIG (1 cycle): picker_config_valid=1, picker_stride_size=stride-1; row, col, row_phase, col_phase cleared -> RUN.
- busy=1 in CONFIG, RUN, FLUSH; cfg_ready=0 there. cfg_valid and start are ignored outside IDLE.
- RUN handshake: s_ready = !m_valid || m_ready. A beat transfers when s_valid && s_ready.
- Per beat: keep iff row_phase==0 && col_phase==0.
- Kept beat loads the output register next cycle: m_data=s_data, m_row=out_row, m_col=out_col. m_last=1 iff row+stride>=rows and col+stride>=cols.
- Dropped beat is consumed with no output.
- Latency: 1 cycle s->m. m_* hold stable while m_valid && !m_ready. m_valid clears on m_ready unless a new kept beat loads the same cycle.
- Column advance: col++, col_phase = (col_phase==stride-1)?0:col_phase+1, out_col++ when col_phase wraps.
- End of row (col==cols-1): col, col_phase, out_col cleared; row advances with the same phase/out_row rule.
- Beat at row==rows-1, col==cols-1 -> FLUSH; s_ready=0 from the next cycle.
- FLUSH: wait until m_valid==0 or (m_valid && m_ready) -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Width rules: counters are C_DIM_WIDTH bits; comparisons are done in C_DIM_WIDTH+1 bits so row+stride does not overflow.
- Boundaries:
  - rows or cols < stride: only index 0 is kept on that axis.
  - 1x1 frame: one output with m_last=1.
  - stride 1: pass-through, every beat kept.
  - s_ready=0 in IDLE, CONFIG, FLUSH, DONE.

Test Plan:
- cfg 4x4 stride 2, data=raster index 0..15, m_ready=1 -> outputs 0,2,8,10 at (0,0),(0,1),(1,0),(1,1); m_last only on 10; done 2 cycles after 15 accepted; picker_stride_size=1 pulsed once.
- cfg 3x3 stride 1 -> all 9 pixels in order, m_row/m_col equal input coordinates, m_last on 8.
- cfg 5x5 stride 2 with m_ready toggling 1010..., random s_valid gaps -> exactly 9 outputs 0,2,4,10,12,14,20,22,24; no data loss or duplication; m_data stable while stalled; m_last on 24.
- cfg rows=0 -> cfg_err=1, start ignored (busy stays 0). Then cfg 2x2 stride 0 -> cfg_err=0, stride treated as 1, 4 outputs.
- start with cfg_valid in the same cycle -> ignored. cfg_valid during RUN -> cfg_ready=0 and config unchanged.
- Assert rst mid-frame after 6 beats -> all outputs 0 immediately, no done. New start after reset with re-cfg -> correct full frame.
